// File: rtl/morse_pkg.sv
// Shared constants and entry-layout helpers for the Morse character assembler.
// An entry is packed as {code, count, word_end, overflow}, with overflow in bit 0.
package morse_pkg;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;

    localparam int OVF_BIT  = 0;
    localparam int WEND_BIT = 1;
    localparam int CNT_LSB  = 2;

    typedef enum logic {ST_IDLE, ST_COLLECT} asm_state_t;

    function automatic int cnt_width(input int max_syms);
        return $clog2(max_syms + 1);
    endfunction

    function automatic int code_lsb(input int max_syms);
        return CNT_LSB + cnt_width(max_syms);
    endfunction

    function automatic int entry_width(input int max_syms);
        return 2 * max_syms + cnt_width(max_syms) + 2;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// Synchronous show-ahead FIFO; the head word is driven directly from the array.
// The read data is forced to zero while empty so that downstream outputs stay quiet.
module morse_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_rd;
    logic             do_wr;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LW'(DEPTH));
    assign level = level_reg;
    assign do_rd = rd_en & ~empty;
    // When full, a write is only accepted if the head is leaving in the same cycle.
    assign do_wr = wr_en & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/morse_char_assembler.sv
// Collects dot/dash pulses into per-character codes and queues them, tagged with
// word-end and overflow status, behind a show-ahead valid/ready read port.
module morse_char_assembler
    import morse_pkg::*;
#(
    parameter int MAX_SYMS   = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_W     = 2 * MAX_SYMS,
    parameter int CNT_W      = $clog2(MAX_SYMS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            writing,
    input  logic                            dot,
    input  logic                            dash,
    input  logic                            interchar,
    input  logic                            interword,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [CODE_W-1:0]               out_code,
    output logic [CNT_W-1:0]                out_count,
    output logic                            out_word_end,
    output logic                            out_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            busy,
    output logic                            drop_err
);
    localparam int ENT_W    = entry_width(MAX_SYMS);
    localparam int CODE_LSB = code_lsb(MAX_SYMS);

    asm_state_t        state_reg, state_next;
    logic [CODE_W-1:0] acc_reg, acc_next, acc_app;
    logic [CNT_W-1:0]  count_reg, count_next, count_app;
    logic              ovf_reg, ovf_next, ovf_app;
    logic              lww_reg, lww_next, lww_app;
    logic              drop_err_reg;

    logic              sym_valid;
    logic [1:0]        sym;
    logic              gap_any;
    logic              gap_word;
    logic              push;
    logic [ENT_W-1:0]  push_entry;
    logic [ENT_W-1:0]  head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign sym_valid = writing & (dot ^ dash);
    assign sym       = dot ? SYM_DOT : SYM_DASH;
    assign gap_any   = writing & (interchar | interword);
    assign gap_word  = writing & interword;
    assign pop       = ~fifo_empty & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            lww_reg      <= 1'b1;
            drop_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            lww_reg   <= lww_next;
            if (push & fifo_full & ~pop) begin
                drop_err_reg <= 1'b1;
            end
        end
    end

    // A symbol arriving with a gap is appended first, so the pushed entry includes it.
    always_comb begin
        acc_app   = acc_reg;
        count_app = count_reg;
        ovf_app   = ovf_reg;
        lww_app   = lww_reg;
        if (sym_valid) begin
            lww_app = 1'b0;
            if (count_reg == CNT_W'(MAX_SYMS)) begin
                ovf_app = 1'b1;
            end else begin
                acc_app   = CODE_W'({acc_reg, sym});
                count_app = count_reg + CNT_W'(1);
            end
        end

        acc_next   = acc_app;
        count_next = count_app;
        ovf_next   = ovf_app;
        lww_next   = lww_app;
        push       = 1'b0;
        push_entry = '0;
        if (gap_any && (count_app != '0)) begin
            push       = 1'b1;
            push_entry = {acc_app, count_app, gap_word, ovf_app};
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
            lww_next   = gap_word | lww_app;
        end else if (gap_word) begin
            // Only the first word gap after a character yields a space entry.
            push       = ~lww_app;
            push_entry = {CODE_W'(0), CNT_W'(0), 1'b1, 1'b0};
            lww_next   = 1'b1;
        end

        state_next = (count_next != '0) ? ST_COLLECT : ST_IDLE;
    end

    always_comb begin
        busy = (state_reg == ST_COLLECT);
    end

    morse_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (out_ready),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid    = ~fifo_empty;
    assign out_code     = head_entry[CODE_LSB +: CODE_W];
    assign out_count    = head_entry[CNT_LSB +: CNT_W];
    assign out_word_end = head_entry[WEND_BIT];
    assign out_overflow = head_entry[OVF_BIT];
    assign drop_err     = drop_err_reg;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Randomised plus directed bench: a symbol-queue reference model feeds a scoreboard
// that a negedge monitor drains whenever the DUT presents a head entry.
module tb_morse_char_assembler;
    localparam int MAX   = 5;
    localparam int DEPTH = 8;
    localparam int CW    = 2 * MAX;
    localparam int CNTW  = $clog2(MAX + 1);
    localparam int LW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset, writing, dot, dash, interchar, interword, out_ready;
    logic            out_valid, out_word_end, out_overflow, busy, drop_err;
    logic [CW-1:0]   out_code;
    logic [CNTW-1:0] out_count;
    logic [LW-1:0]   fifo_level;

    morse_char_assembler #(.MAX_SYMS(MAX), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .writing      (writing),
        .dot          (dot),
        .dash         (dash),
        .interchar    (interchar),
        .interword    (interword),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_code     (out_code),
        .out_count    (out_count),
        .out_word_end (out_word_end),
        .out_overflow (out_overflow),
        .fifo_level   (fifo_level),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int cnt;
        bit we;
        bit ov;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: the character in progress is a list of symbols (1=dot, 2=dash).
    int   syms[$];
    bit   m_ovf, m_lww, m_drop;
    int   m_level;
    bit   pend_push, pend_flush;
    ent_t pend_ent;
    int   e_level;
    bit   e_drop, e_busy;
    bit   mon_en = 1'b0;
    bit   rdy, rst;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model(input bit w, input bit d, input bit da, input bit ic, input bit iw);
        bit   pop, push;
        ent_t e;
        if (rst) begin
            syms.delete();
            m_ovf = 0; m_lww = 1; m_level = 0; m_drop = 0;
            pend_flush = 1; pend_push = 0;
            return;
        end
        pop  = (m_level > 0) && rdy;
        push = 0;
        e    = '{0, 0, 0, 0};
        if (w && (d != da)) begin
            if (syms.size() < MAX) syms.push_back(d ? 1 : 2);
            else m_ovf = 1;
            m_lww = 0;
        end
        if (w && (ic || iw)) begin
            if (syms.size() > 0) begin
                foreach (syms[k]) e.code = (e.code << 2) | syms[k];
                e.cnt = syms.size(); e.we = iw; e.ov = m_ovf;
                push = 1;
                syms.delete(); m_ovf = 0;
                if (iw) m_lww = 1;
            end else if (iw) begin
                if (!m_lww) begin
                    e.we = 1; push = 1;
                end
                m_lww = 1;
            end
        end
        if (push) begin
            if (m_level == DEPTH && !pop) m_drop = 1;
            else begin
                pend_push = 1; pend_ent = e;
            end
        end
        m_level = m_level + (pend_push ? 1 : 0) - (pop ? 1 : 0);
    endtask

    task automatic step(input bit w, input bit d, input bit da, input bit ic, input bit iw);
        reset = rst; out_ready = rdy;
        writing = w; dot = d; dash = da; interchar = ic; interword = iw;
        model(w, d, da, ic, iw);
        @(posedge clk);
        if (pend_flush) exp_q.delete();
        if (pend_push) exp_q.push_back(pend_ent);
        pend_flush = 0; pend_push = 0;
        e_level = m_level; e_drop = m_drop; e_busy = (syms.size() > 0);
        mon_en = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
    endtask

    task automatic send_char(input int i);
        bit b;
        for (int j = 0; j < 1 + (i % MAX); j++) begin
            b = i[j];
            step(1, b, !b, 0, 0);
        end
        step(1, 0, 0, 1, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("fifo_level", fifo_level, e_level);
            chk("drop_err", drop_err, e_drop);
            chk("busy", busy, e_busy);
            if (exp_q.size() > 0) begin
                chk("out_code", out_code, exp_q[0].code);
                chk("out_count", out_count, exp_q[0].cnt);
                chk("out_word_end", out_word_end, exp_q[0].we);
                chk("out_overflow", out_overflow, exp_q[0].ov);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("empty_code", out_code, 0);
                chk("empty_count", out_count, 0);
                chk("empty_flags", {out_word_end, out_overflow}, 0);
            end
        end
    end

    initial begin
        bit w, d, da, ic, iw;
        rdy = 0; rst = 1;
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        rst = 0;
        // dot, dash, interchar -> code 0x006, count 2
        step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 0, 0, 1, 0); idle(2);
        // seven dots then a word gap, then a dash merged with its closing gap
        repeat (7) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1); step(1, 0, 1, 1, 0);
        // "A" closed by a word gap, repeated word gaps, then a single space
        step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 1);
        repeat (3) step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1);
        rdy = 1; idle(10); rdy = 0;
        // nine characters into an eight-deep FIFO, then drain
        for (int i = 0; i < 9; i++) send_char(i + 3);
        idle(2); rdy = 1; idle(9); rdy = 0;
        // full FIFO with simultaneous push and pop
        rst = 1; step(0, 0, 0, 0, 0); rst = 0;
        for (int i = 0; i < DEPTH; i++) send_char(i);
        step(1, 0, 1, 0, 0); step(1, 1, 0, 0, 0);
        rdy = 1; step(1, 0, 0, 1, 0); rdy = 0; idle(2);
        rdy = 1; idle(10);
        // noise, gated pulses, held partial character, reset mid-collection
        step(1, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0); step(1, 1, 1, 0, 0); step(0, 0, 1, 1, 0);
        step(1, 0, 1, 0, 0); step(1, 0, 0, 1, 0);
        rdy = 0;
        for (int i = 0; i < 3; i++) send_char(i + 7);
        step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0);
        rst = 1; step(1, 1, 0, 0, 0); rst = 0; idle(2);
        // randomised traffic with alternating back-pressure phases
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ((i / 400) % 2 == 1) rdy = ($urandom_range(0, 5) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 7) != 0);
            d  = ($urandom_range(0, 9) < 3);
            da = ($urandom_range(0, 9) < 3);
            ic = ($urandom_range(0, 99) < 12);
            iw = ($urandom_range(0, 99) < 6);
            step(w, d, da, ic, iw);
        end
        rst = 0; rdy = 1; idle(20);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
